// File: rtl/apb_slave_regfile_pkg.sv
// Shared definitions for the APB register-file slave: bus width, FSM encoding
// and the default identification word returned by register 0.
package apb_slave_regfile_pkg;

  localparam int APB_WIDTH = 32;
  localparam int APB_CNT_W = 4;
  localparam logic [31:0] APB_ID_VALUE = 32'hA5B0_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } apb_state_e;

  // Number of word-index bits needed to address a bank of the given depth.
  function automatic int apb_index_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter that paces the access phase; done marks the last
// wait cycle so the FSM can move to the response on the following edge.
module apb_wait_counter
  import apb_slave_regfile_pkg::*;
#(
  parameter int CNT_W = APB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_slave_regfile.sv
// APB register-bank responder with configurable wait states and error
// signalling for out-of-range accesses and writes to the read-only ID word.
module apb_slave_regfile
  import apb_slave_regfile_pkg::*;
#(
  parameter int               WIDTH       = APB_WIDTH,
  parameter int               DEPTH       = 16,
  parameter int               WAIT_STATES = 0,
  parameter logic [WIDTH-1:0] ID_VALUE    = APB_ID_VALUE
) (
  input  logic             Pclk,
  input  logic             Preset,
  input  logic             Psel,
  input  logic             Penable,
  input  logic             Pwrite,
  input  logic [WIDTH-1:0] Paddr,
  input  logic [WIDTH-1:0] Pwdata,
  output logic [WIDTH-1:0] Prdata,
  output logic             Pready,
  output logic             Pslverr
);

  localparam int AW = apb_index_bits(DEPTH);
  localparam logic [APB_CNT_W-1:0] WAIT_LOAD = APB_CNT_W'(WAIT_STATES);

  apb_state_e state_q, state_d;

  logic [WIDTH-3:0] addr_q;
  logic             write_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] regs [DEPTH];

  logic             setup_phase;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_done;
  logic             enter_resp;
  logic             do_write;

  logic [WIDTH-3:0] req_addr;
  logic             req_write;
  logic [AW-1:0]    req_idx;
  logic             req_in_range;
  logic             req_err;
  logic [WIDTH-1:0] rd_word;

  logic             unused_paddr_bits;
  assign unused_paddr_bits = ^Paddr[1:0];

  assign setup_phase = Psel && !Penable;

  // With no wait states the response is built in the setup cycle itself, so
  // the live bus request is used while idle and the latched copy afterwards.
  assign req_addr     = (state_q == ST_IDLE) ? Paddr[WIDTH-1:2] : addr_q;
  assign req_write    = (state_q == ST_IDLE) ? Pwrite : write_q;
  assign req_idx      = req_addr[AW-1:0];
  assign req_in_range = ((req_addr >> AW) == '0);
  assign req_err      = !req_in_range || (req_write && (req_idx == '0));
  assign rd_word      = regs[req_idx];

  apb_wait_counter #(
    .CNT_W(APB_CNT_W)
  ) u_wait_counter (
    .clk       (Pclk),
    .rst       (Preset),
    .load      (cnt_load),
    .load_value(WAIT_LOAD),
    .dec       (cnt_dec),
    .done      (cnt_done)
  );

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    enter_resp = 1'b0;
    do_write   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup_phase) begin
          cnt_load = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!Psel) begin
          state_d = ST_IDLE;
        end else if (cnt_done) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        do_write = Psel && Penable && write_q && !req_err;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (cnt_load) begin
      addr_q  <= Paddr[WIDTH-1:2];
      write_q <= Pwrite;
      wdata_q <= Pwdata;
    end
  end

  // Entry 0 holds the ID word; the error path keeps writes from ever reaching it.
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == 0) ? ID_VALUE : '0;
      end
    end else if (do_write) begin
      regs[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= '0;
    end else if (enter_resp) begin
      Pready  <= 1'b1;
      Pslverr <= req_err;
      Prdata  <= (req_err || req_write) ? '0 : rd_word;
    end else begin
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= '0;
    end
  end

endmodule
